// File: rtl/regfile_fetch.sv
// Operand-fetch stage: register file with r0 hardwired to zero, write-to-read
// bypass, and a registered valid/ready operand slot toward the execute stage.
module regfile_fetch #(
  parameter int width     = 8,
  parameter int addr_bits = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [addr_bits-1:0] wr_addr,
  input  logic [width-1:0]     wr_data,
  input  logic                 rd_valid_IN,
  output logic                 rd_ready_OUT,
  input  logic [addr_bits-1:0] rd_addr_a,
  input  logic [addr_bits-1:0] rd_addr_b,
  output logic                 op_valid_OUT,
  input  logic                 op_ready_IN,
  output logic [width-1:0]     op_a_OUT,
  output logic [width-1:0]     op_b_OUT,
  output logic [15:0]          stall_cnt_OUT
);

  localparam int unsigned NREG = 2 ** addr_bits;

  typedef enum logic {EMPTY, FULL} slot_state_t;

  slot_state_t          state, state_nxt;
  logic [width-1:0]     regs [NREG];
  logic [width-1:0]     rd_a, rd_b;
  logic [width-1:0]     op_a_q, op_b_q;
  logic [15:0]          stall_cnt;
  logic                 accept, stall;

  assign op_valid_OUT  = (state == FULL);
  assign rd_ready_OUT  = ~op_valid_OUT | op_ready_IN;
  assign accept        = rd_valid_IN & rd_ready_OUT;
  assign stall         = op_valid_OUT & ~op_ready_IN;
  assign op_a_OUT      = op_a_q;
  assign op_b_OUT      = op_b_q;
  assign stall_cnt_OUT = stall_cnt;

  // Read-select with same-cycle writeback bypass; index 0 always reads zero.
  always_comb begin
    rd_a = regs[rd_addr_a];
    if (wr_en && (wr_addr == rd_addr_a)) rd_a = wr_data;
    if (rd_addr_a == '0) rd_a = '0;

    rd_b = regs[rd_addr_b];
    if (wr_en && (wr_addr == rd_addr_b)) rd_b = wr_data;
    if (rd_addr_b == '0) rd_b = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL:  if (op_ready_IN && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      op_a_q    <= '0;
      op_b_q    <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a_q <= rd_a;
        op_b_q <= rd_b;
      end
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
